// File: rtl/nd_1ton.sv
// 1-to-N message router: four-phase input channel, range-table routing with
// first-match priority, per-output FIFOs and independent four-phase outputs.
//
// state        | meaning
// IN_IDLE      | waiting for a synchronised request with room in the target
// IN_ACKED     | message taken (or dropped), ack held until request falls
// OUT_IDLE     | output idle; loads the FIFO head once the last ack is released
// OUT_SENDING  | snd_req high, waiting for the receiver's ack
// OUT_WAIT_REL | snd_req low, waiting for the receiver to drop its ack
module nd_1ton #(
  parameter int NOUT = 4,
  parameter int FSZ  = 4,
  parameter int ASZ  = 8,
  parameter int DSZ  = 16,
  parameter int RSZ  = 4,
  parameter logic [NOUT*ASZ-1:0] LO_BOUNDS = '0,
  parameter logic [NOUT*ASZ-1:0] HI_BOUNDS = '1,
  parameter int DFLT_OUT = 0,
  parameter bit DROP_UNMATCHED = 1'b0
) (
  input  logic                          gch_clk,
  input  logic                          gch_reset_n,
  output logic                          gch_ready,
  input  logic                          rcv0_req,
  output logic                          rcv0_ack,
  input  logic [ASZ-1:0]                rcv0_src,
  input  logic [ASZ-1:0]                rcv0_dst,
  input  logic [DSZ-1:0]                rcv0_dat,
  input  logic [RSZ-1:0]                rcv0_red,
  output logic [NOUT-1:0]               snd_req,
  input  logic [NOUT-1:0]               snd_ack,
  output logic [NOUT*ASZ-1:0]           snd_src,
  output logic [NOUT*ASZ-1:0]           snd_dst,
  output logic [NOUT*DSZ-1:0]           snd_dat,
  output logic [NOUT*RSZ-1:0]           snd_red,
  output logic [NOUT*($clog2(FSZ)+1)-1:0] occ,
  output logic [15:0]                   drop_cnt
);

  localparam int PW = $clog2(FSZ);
  localparam int OW = PW + 1;
  localparam int MW = 2*ASZ + DSZ + RSZ;
  localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;

  typedef enum logic {IN_IDLE, IN_ACKED} in_st_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SENDING, OUT_WAIT_REL} out_st_t;

  logic            req_s1, req_s;
  logic [NOUT-1:0] ack_s1, ack_s;
  logic            init_done;
  in_st_t          in_st;
  logic            hit, drop, accept;
  logic [IW-1:0]   tgt;
  logic [NOUT-1:0] full;
  logic [MW-1:0]   msg_in;

  always_ff @(posedge gch_clk or negedge gch_reset_n) begin
    if (!gch_reset_n) begin
      req_s1    <= 1'b0;
      req_s     <= 1'b0;
      ack_s1    <= '0;
      ack_s     <= '0;
      init_done <= 1'b0;
      gch_ready <= 1'b0;
    end else begin
      req_s1    <= rcv0_req;
      req_s     <= req_s1;
      ack_s1    <= snd_ack;
      ack_s     <= ack_s1;
      init_done <= 1'b1;
      gch_ready <= init_done;
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    tgt = IW'(DFLT_OUT);
    for (int k = NOUT-1; k >= 0; k--) begin
      if (rcv0_dst >= LO_BOUNDS[k*ASZ +: ASZ] && rcv0_dst <= HI_BOUNDS[k*ASZ +: ASZ]) begin
        hit = 1'b1;
        tgt = IW'(k);
      end
    end
  end

  assign drop   = DROP_UNMATCHED && !hit;
  assign msg_in = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
  assign accept = (in_st == IN_IDLE) && gch_ready && req_s && (drop || !full[tgt]);

  always_ff @(posedge gch_clk or negedge gch_reset_n) begin
    if (!gch_reset_n) begin
      in_st    <= IN_IDLE;
      rcv0_ack <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (in_st)
        IN_IDLE: begin
          if (accept) begin
            rcv0_ack <= 1'b1;
            in_st    <= IN_ACKED;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
        end
        IN_ACKED: begin
          if (!req_s) begin
            rcv0_ack <= 1'b0;
            in_st    <= IN_IDLE;
          end
        end
        default: in_st <= IN_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    logic [MW-1:0] mem [FSZ];
    logic [PW-1:0] wp, rp;
    logic [OW-1:0] cnt;
    logic [MW-1:0] msg_q;
    logic          req_q;
    out_st_t       st;
    logic          push, pop;

    assign push    = accept && !drop && (tgt == IW'(k));
    assign pop     = (st == OUT_IDLE) && (cnt != '0) && !ack_s[k];
    assign full[k] = (cnt == OW'(FSZ));

    // Payload storage needs no reset; only pointers and count define contents.
    always_ff @(posedge gch_clk) begin
      if (push) mem[wp] <= msg_in;
    end

    always_ff @(posedge gch_clk or negedge gch_reset_n) begin
      if (!gch_reset_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge gch_clk or negedge gch_reset_n) begin
      if (!gch_reset_n) begin
        st    <= OUT_IDLE;
        req_q <= 1'b0;
        msg_q <= '0;
      end else begin
        case (st)
          OUT_IDLE: begin
            if (pop) begin
              msg_q <= mem[rp];
              req_q <= 1'b1;
              st    <= OUT_SENDING;
            end
          end
          OUT_SENDING: begin
            if (ack_s[k]) begin
              req_q <= 1'b0;
              st    <= OUT_WAIT_REL;
            end
          end
          OUT_WAIT_REL: begin
            if (!ack_s[k]) st <= OUT_IDLE;
          end
          default: st <= OUT_IDLE;
        endcase
      end
    end

    assign snd_req[k] = req_q;
    assign {snd_src[k*ASZ +: ASZ], snd_dst[k*ASZ +: ASZ],
            snd_dat[k*DSZ +: DSZ], snd_red[k*RSZ +: RSZ]} = msg_q;
    assign occ[k*OW +: OW] = cnt;
  end

endmodule

// File: tb/tb_nd_1ton.sv
// Bench for nd_1ton: three routers (plain ranges, overlapping ranges with a
// default output, overlapping ranges with drop) checked against a scoreboard.
module tb_nd_1ton;

  typedef logic [35:0] msg_t;

  localparam logic [31:0] LO_A = {8'd192, 8'd128, 8'd64,  8'd0};
  localparam logic [31:0] HI_A = {8'd255, 8'd191, 8'd127, 8'd63};
  localparam logic [31:0] LO_B = {8'h60,  8'h10,  8'h00,  8'h00};
  localparam logic [31:0] HI_B = {8'h7F,  8'h1F,  8'h7F,  8'h0F};

  int lo_t [3][4] = '{'{0, 64, 128, 192}, '{0, 0, 16, 96}, '{0, 0, 16, 96}};
  int hi_t [3][4] = '{'{63, 127, 191, 255}, '{15, 127, 31, 127}, '{15, 127, 31, 127}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ready, req, ack;
  logic [7:0]  src [3];
  logic [7:0]  dst [3];
  logic [15:0] dat [3];
  logic [3:0]  red [3];
  logic [3:0]  sreq [3];
  logic [3:0]  sack [3];
  logic [31:0] ssrc [3];
  logic [31:0] sdst [3];
  logic [63:0] sdat [3];
  logic [15:0] sred [3];
  logic [11:0] occv [3];
  logic [15:0] dcnt [3];
  logic        stall [3][4];

  msg_t exp_q [12][$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    nd_1ton #(
      .NOUT(4), .FSZ(4), .ASZ(8), .DSZ(16), .RSZ(4),
      .LO_BOUNDS(i == 0 ? LO_A : LO_B),
      .HI_BOUNDS(i == 0 ? HI_A : HI_B),
      .DFLT_OUT(i == 0 ? 0 : 2),
      .DROP_UNMATCHED(i == 2 ? 1'b1 : 1'b0)
    ) u_dut (
      .gch_clk(clk), .gch_reset_n(rst_n), .gch_ready(ready[i]),
      .rcv0_req(req[i]), .rcv0_ack(ack[i]),
      .rcv0_src(src[i]), .rcv0_dst(dst[i]), .rcv0_dat(dat[i]), .rcv0_red(red[i]),
      .snd_req(sreq[i]), .snd_ack(sack[i]),
      .snd_src(ssrc[i]), .snd_dst(sdst[i]), .snd_dat(sdat[i]), .snd_red(sred[i]),
      .occ(occv[i]), .drop_cnt(dcnt[i])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int route(int d, logic [7:0] a);
    for (int k = 0; k < 4; k++)
      if (int'(a) >= lo_t[d][k] && int'(a) <= hi_t[d][k]) return k;
    return (d == 2) ? -1 : ((d == 0) ? 0 : 2);
  endfunction

  // Receiver per output: check each new message at snd_req rise, ack one
  // cycle later unless stalled, release ack once snd_req falls.
  for (genvar d = 0; d < 3; d++) begin : g_rsp
    for (genvar k = 0; k < 4; k++) begin : g_k
      logic a;
      logic got;
      msg_t m;
      assign sack[d][k] = a;
      initial begin
        a = 1'b0;
        got = 1'b0;
        forever begin
          @(negedge clk);
          #1;
          if (!rst_n) begin
            a = 1'b0;
            got = 1'b0;
          end else if (sreq[d][k] && !got) begin
            got = 1'b1;
            m = {ssrc[d][k*8 +: 8], sdst[d][k*8 +: 8], sdat[d][k*16 +: 16], sred[d][k*4 +: 4]};
            if (exp_q[d*4+k].size() == 0) chk($sformatf("unexp_%0d_%0d", d, k), 1, 0);
            else chk($sformatf("msg_%0d_%0d", d, k), m, exp_q[d*4+k].pop_front());
          end else if (got && !a && sreq[d][k] && !stall[d][k]) begin
            a = 1'b1;
          end else if (a && !sreq[d][k]) begin
            a = 1'b0;
            got = 1'b0;
          end
        end
      end
    end
  end

  task automatic start_send(input int d, input logic [7:0] s, input logic [7:0] t,
                            input logic [15:0] v, input logic [3:0] r);
    int k;
    k = route(d, t);
    if (k >= 0) exp_q[d*4+k].push_back({s, t, v, r});
    src[d] = s; dst[d] = t; dat[d] = v; red[d] = r;
    req[d] = 1'b1;
  endtask

  task automatic finish_send(input int d);
    int n;
    n = 0;
    while (!ack[d] && n < 60) begin @(negedge clk); n++; end
    chk($sformatf("ack_rise_%0d", d), ack[d], 1);
    req[d] = 1'b0;
    n = 0;
    while (ack[d] && n < 60) begin @(negedge clk); n++; end
    if (ack[d]) chk($sformatf("ack_fall_%0d", d), ack[d], 0);
    @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] s, input logic [7:0] t,
                      input logic [15:0] v, input logic [3:0] r);
    start_send(d, s, t, v, r);
    finish_send(d);
  endtask

  task automatic wait_drain(input int d);
    int n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      busy = (sreq[d] != 4'b0) || (sack[d] != 4'b0);
      for (int k = 0; k < 4; k++) if (exp_q[d*4+k].size() != 0) busy = 1'b1;
    end
    chk($sformatf("drain_%0d", d), busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    req = '0;
    for (int d = 0; d < 3; d++) begin
      src[d] = '0; dst[d] = '0; dat[d] = '0; red[d] = '0;
      for (int k = 0; k < 4; k++) stall[d][k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", ready[0], 0);
    chk("rst_ack", ack[0], 0);
    chk("rst_sreq", sreq[0], 0);
    chk("rst_occ", occv[0], 0);
    chk("rst_dcnt", dcnt[0], 0);
    chk("rst_sdat", sdat[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_edge1", ready[0], 0);
    @(negedge clk);
    chk("ready_edge2", ready[0], 1);

    // Range routing, with input and forwarding latency on the first message.
    start_send(0, 8'h11, 8'h05, 16'hA5A5, 4'h3);
    lat = 0;
    while (!ack[0] && lat < 20) begin @(negedge clk); lat++; end
    chk("in_latency", lat, 3);
    chk("fwd_before", sreq[0], 4'b0000);
    @(negedge clk);
    chk("fwd_after", sreq[0], 4'b0001);
    chk("occ_after_pop", occv[0], 0);
    finish_send(0);
    send(0, 8'h22, 8'h50, 16'h1234, 4'h5);
    send(0, 8'h33, 8'hA0, 16'hBEEF, 4'hA);
    send(0, 8'h44, 8'hFF, 16'h0F0F, 4'hF);
    wait_drain(0);

    // Overlapping ranges and default output.
    send(1, 8'h55, 8'h14, 16'h1414, 4'h1);
    send(1, 8'h66, 8'h80, 16'h8080, 4'h2);
    wait_drain(1);
    chk("dcnt_no_drop", dcnt[1], 0);

    // Drop policy.
    send(2, 8'h77, 8'h80, 16'hDEAD, 4'h7);
    wait_drain(2);
    chk("dcnt_drop", dcnt[2], 1);
    chk("drop_no_req", sreq[2], 0);

    // Fill output 0, head-of-line block, drain with pointer wrap.
    stall[0][0] = 1'b1;
    for (int i = 0; i < 5; i++) send(0, 8'(8'h80 + i), 8'(i), 16'(16'h100 + i), 4'(i));
    chk("occ_full", occv[0][2:0], 4);
    start_send(0, 8'h85, 8'h05, 16'h0105, 4'h5);
    repeat (10) @(negedge clk);
    chk("hol_block", ack[0], 0);
    chk("occ_full_hold", occv[0][2:0], 4);
    stall[0][0] = 1'b0;
    finish_send(0);
    wait_drain(0);

    // Output 1 drains while output 0 is stalled full.
    stall[0][0] = 1'b1;
    stall[0][1] = 1'b1;
    send(0, 8'hA0, 8'h00, 16'h2000, 4'h0);
    send(0, 8'hB0, 8'h40, 16'h3000, 4'h1);
    send(0, 8'hB1, 8'h41, 16'h3001, 4'h2);
    for (int i = 1; i < 5; i++) send(0, 8'(8'hA0 + i), 8'(i), 16'(16'h2000 + i), 4'(i));
    chk("iso_occ0", occv[0][2:0], 4);
    chk("iso_occ1", occv[0][5:3], 1);
    send(0, 8'hB2, 8'h42, 16'h3002, 4'h3);
    chk("iso_occ1_b", occv[0][5:3], 2);
    stall[0][1] = 1'b0;
    repeat (60) @(negedge clk);
    chk("iso_out1_drained", exp_q[1].size(), 0);
    chk("iso_out0_held", occv[0][2:0], 4);
    start_send(0, 8'hA5, 8'h05, 16'h2005, 4'h5);
    repeat (10) @(negedge clk);
    chk("iso_hol", ack[0], 0);
    stall[0][0] = 1'b0;
    finish_send(0);
    wait_drain(0);

    // Reset in the middle of a handshake on output 2.
    stall[0][2] = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 8'(8'hC0 + i), 8'(8'h80 + i), 16'(16'h4000 + i), 4'(i));
    chk("pre_rst_sreq2", sreq[0][2], 1);
    chk("pre_rst_occ2", occv[0][8:6], 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sreq", sreq[0], 0);
    chk("mid_rst_occ", occv[0], 0);
    chk("mid_rst_ready", ready[0], 0);
    chk("mid_rst_sdat", sdat[0], 0);
    exp_q[2].delete();
    stall[0][2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_e1", ready[0], 0);
    @(negedge clk);
    chk("rel_ready_e2", ready[0], 1);
    send(0, 8'hD0, 8'h90, 16'h5000, 4'h9);
    send(0, 8'hD1, 8'hC0, 16'h5001, 4'hC);
    wait_drain(0);
    chk("post_rst_occ", occv[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
